// File: rtl/gamepad_scanner.sv
// gamepad_scanner: serially scans two GameTank pads and latches their button bytes into CPU registers.
// Optional GAMEPAD_AUTOPOLL_EN adds a free-running timer that requests a scan every POLL_PERIOD cycles.

module gamepad_lane #(
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             data,
    input  logic             sample,
    input  logic [IDXW-1:0]  idx,
    output logic [NBITS-1:0] shift
);
    logic [1:0] sync;

    // Idle pad line reads high (not pressed), so the synchronizer resets to 1.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync  <= 2'b11;
            shift <= '0;
        end else begin
            sync <= {sync[0], data};
            if (sample) shift[idx] <= ~sync[1];
        end
    end
endmodule

module gamepad_scanner #(
    parameter int CLK_DIV = 4,
    parameter int NBITS   = 8
`ifdef GAMEPAD_AUTOPOLL_EN
    ,
    parameter logic [15:0] POLL_PERIOD = 16'd50000
`endif
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       scan_done,
    output logic       joy1_strb,
    output logic       joy2_strb,
    output logic       joy1_clk,
    output logic       joy2_clk,
    input  logic       joy1_data,
    input  logic       joy2_data
);
    localparam int              NUM_LANES = 2;
    localparam int              IDXW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NBITS - 1);
    localparam logic [7:0]      PH_LAST   = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, STROBE, LO, HI, DONE} state_t;

    state_t                          state_q, state_d;
    logic [7:0]                      phase_q, phase_d;
    logic [IDXW-1:0]                 idx_q, idx_d;
    logic                            strb, jclk, busy, sample, done, last;
    logic                            start, cpu_start, valid;
    logic [NUM_LANES-1:0]            pad_data;
    logic [NUM_LANES-1:0][NBITS-1:0] shift;
    logic [NUM_LANES-1:0][7:0]       pad;
    logic                            unused_wdata;

    assign pad_data     = {joy2_data, joy1_data};
    assign cpu_start    = cs && wr && (addr == 2'd2) && wdata[0];
    assign unused_wdata = ^wdata[7:1];
    assign last         = (phase_q == PH_LAST);

`ifdef GAMEPAD_AUTOPOLL_EN
    logic [15:0] poll_cnt;
    logic        tick;

    assign tick  = (poll_cnt == POLL_PERIOD - 16'd1);
    // Timer and CPU requests merge into one start; either is dropped unless IDLE.
    assign start = cpu_start || tick;

    always_ff @(posedge sys_clk) begin
        if (reset || tick) poll_cnt <= '0;
        else               poll_cnt <= poll_cnt + 16'd1;
    end
`else
    assign start = cpu_start;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        gamepad_lane #(.NBITS(NBITS), .IDXW(IDXW)) u_lane (
            .sys_clk (sys_clk),
            .reset   (reset),
            .data    (pad_data[i]),
            .sample  (sample),
            .idx     (idx_q),
            .shift   (shift[i])
        );
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = last ? 8'd0 : phase_q + 8'd1;
        idx_d   = idx_q;
        strb    = 1'b0;
        jclk    = 1'b0;
        busy    = 1'b1;
        sample  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy    = 1'b0;
                phase_d = '0;
                idx_d   = '0;
                if (start) state_d = STROBE;
            end
            STROBE: begin
                strb = 1'b1;
                if (last) begin
                    state_d = LO;
                    idx_d   = '0;
                end
            end
            LO: begin
                if (last) begin
                    sample  = 1'b1;
                    state_d = (idx_q == IDX_LAST) ? DONE : HI;
                end
            end
            HI: begin
                jclk = 1'b1;
                if (last) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LO;
                end
            end
            DONE: begin
                done    = 1'b1;
                phase_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad registers only change in DONE, so reads during a scan see the previous result.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pad       <= '0;
            valid     <= 1'b0;
            scan_done <= 1'b0;
            rdata     <= '0;
        end else begin
            scan_done <= done;
            if (state_q == IDLE && start) valid <= 1'b0;
            if (done) begin
                valid  <= 1'b1;
                pad[0] <= 8'(shift[0]);
                pad[1] <= 8'(shift[1]);
            end
            if (cs && rd) begin
                case (addr)
                    2'd0:    rdata <= pad[0];
                    2'd1:    rdata <= pad[1];
                    2'd2:    rdata <= {6'b0, valid, busy};
                    default: rdata <= 8'h00;
                endcase
            end
        end
    end

    assign joy1_strb = strb;
    assign joy2_strb = strb;
    assign joy1_clk  = jclk;
    assign joy2_clk  = jclk;
endmodule

// File: tb/tb_gamepad_scanner.sv
// Bench for gamepad_scanner: pad models answer the strobe/clock pins, and each scan is checked
// against button values, pulse counts and latency derived from the scan rules.
module tb_gamepad_scanner;
`ifdef GAMEPAD_AUTOPOLL_EN
    localparam int NI = 3;
`else
    localparam int NI = 2;
`endif

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [1:0]    addr  = '0;
    logic [7:0]    wdata = '0;
    int            sel   = 0;
    logic [NI-1:0] cs_v, done_v, s1, s2, c1, c2, d1, d2;
    logic [7:0]    rdata_v [NI];
    logic [7:0]    btn     [NI][2];
    logic [7:0]    exp_p   [NI][2];
    int            checks = 0;
    int            errors = 0;

    always #5 sys_clk = ~sys_clk;

    assign cs_v = cs ? ({{(NI-1){1'b0}}, 1'b1} << sel) : '0;

    gamepad_scanner u_dut (
        .sys_clk(sys_clk), .reset(reset), .cs(cs_v[0]), .addr(addr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata_v[0]), .scan_done(done_v[0]),
        .joy1_strb(s1[0]), .joy2_strb(s2[0]), .joy1_clk(c1[0]), .joy2_clk(c2[0]),
        .joy1_data(d1[0]), .joy2_data(d2[0]));

    gamepad_scanner #(.CLK_DIV(3), .NBITS(4)) u_dut4 (
        .sys_clk(sys_clk), .reset(reset), .cs(cs_v[1]), .addr(addr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata_v[1]), .scan_done(done_v[1]),
        .joy1_strb(s1[1]), .joy2_strb(s2[1]), .joy1_clk(c1[1]), .joy2_clk(c2[1]),
        .joy1_data(d1[1]), .joy2_data(d2[1]));

`ifdef GAMEPAD_AUTOPOLL_EN
    gamepad_scanner #(.POLL_PERIOD(16'd100)) u_dutp (
        .sys_clk(sys_clk), .reset(reset), .cs(cs_v[2]), .addr(addr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata_v[2]), .scan_done(done_v[2]),
        .joy1_strb(s1[2]), .joy2_strb(s2[2]), .joy1_clk(c1[2]), .joy2_clk(c2[2]),
        .joy1_data(d1[2]), .joy2_data(d2[2]));
`endif

    // Pad model: strobe rewinds to button 0, each rising pad clock advances one button.
    for (genvar k = 0; k < NI; k++) begin : g_pad
        int   p1 = 0, p2 = 0;
        logic q1 = 1'b0, q2 = 1'b0;
        always @(posedge sys_clk) begin
            if (s1[k]) p1 <= 0; else if (c1[k] && !q1) p1 <= p1 + 1;
            if (s2[k]) p2 <= 0; else if (c2[k] && !q2) p2 <= p2 + 1;
            q1 <= c1[k];
            q2 <= c2[k];
        end
        assign d1[k] = (p1 < 8) ? ~btn[k][0][p1[2:0]] : 1'b1;
        assign d2[k] = (p2 < 8) ? ~btn[k][1][p2[2:0]] : 1'b1;
    end

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_read(input int s, input logic [1:0] a, output logic [7:0] d);
        sel = s; addr = a; cs = 1'b1; rd = 1'b1;
        cyc();
        cs = 1'b0; rd = 1'b0;
        d = rdata_v[s];
    endtask

    task automatic bus_write(input int s, input logic [1:0] a, input logic [7:0] wd);
        sel = s; addr = a; wdata = wd; cs = 1'b1; wr = 1'b1;
        cyc();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        for (int a = 0; a < 3; a++) begin
            bus_read(0, 2'(a), d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr%0d got %h want 00", a, d);
            end
        end
        checks++;
        if ({s1, s2, c1, c2, done_v} !== '0) begin
            errors++;
            $display("FAIL reset_pins got %b want 0", {s1, s2, c1, c2, done_v});
        end
    endtask

    // One full CPU-started scan, checked against the pin protocol and expected latency.
    task automatic run_scan(input int s, input int nb, input int cd,
                            input logic [7:0] b1, input logic [7:0] b2, input string name);
        int         exp_len, t, strb_n, pulses, plen, bad_plen, done_t, diff;
        logic [7:0] mask, d;
        exp_len = 2 * cd * nb + 1;
        mask    = 8'((1 << nb) - 1);
        btn[s][0] = b1;
        btn[s][1] = b2;
        bus_write(s, 2'd2, 8'h01);
        t = 0; strb_n = 0; pulses = 0; plen = 0; bad_plen = 0; done_t = -1; diff = 0;
        while (done_t < 0 && t < exp_len + 20) begin
            if (s1[s]) strb_n++;
            if (c1[s]) plen++;
            else if (plen != 0) begin
                pulses++;
                if (plen != cd) bad_plen++;
                plen = 0;
            end
            if (s1[s] !== s2[s] || c1[s] !== c2[s]) diff++;
            cyc();
            t++;
            if (done_v[s]) done_t = t;
        end
        checks++;
        if (strb_n != cd) begin errors++; $display("FAIL %s strobe_cycles got %0d want %0d", name, strb_n, cd); end
        checks++;
        if (pulses != nb - 1) begin errors++; $display("FAIL %s clk_pulses got %0d want %0d", name, pulses, nb - 1); end
        checks++;
        if (bad_plen != 0) begin errors++; $display("FAIL %s clk_width got %0d bad pulses want 0", name, bad_plen); end
        checks++;
        if (diff != 0) begin errors++; $display("FAIL %s pad_pins_differ got %0d want 0", name, diff); end
        checks++;
        if (done_t != exp_len) begin errors++; $display("FAIL %s done_latency got %0d want %0d", name, done_t, exp_len); end
        exp_p[s][0] = b1 & mask;
        exp_p[s][1] = b2 & mask;
        bus_read(s, 2'd0, d);
        checks++;
        if (d !== exp_p[s][0]) begin errors++; $display("FAIL %s pad1 got %h want %h", name, d, exp_p[s][0]); end
        bus_read(s, 2'd1, d);
        checks++;
        if (d !== exp_p[s][1]) begin errors++; $display("FAIL %s pad2 got %h want %h", name, d, exp_p[s][1]); end
        bus_read(s, 2'd2, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL %s status got %h want 02", name, d); end
        bus_read(s, 2'd3, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL %s addr3 got %h want 00", name, d); end
    endtask

    task automatic test_fixed_scan();
        run_scan(0, 8, 4, 8'hA5, 8'h3C, "scan_a5_3c");
        run_scan(1, 4, 3, 8'hFF, 8'h0A, "scan_nbits4");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int s = i % 2;
            run_scan(s, (s == 0) ? 8 : 4, (s == 0) ? 4 : 3,
                     8'($urandom), 8'($urandom), $sformatf("random%0d", i));
        end
    endtask

    // Start write during the scan is ignored; reads see the old result until DONE.
    task automatic test_midscan_write();
        logic [7:0] prev, b1;
        int         nd, done_t;
        prev = exp_p[0][0];
        b1   = 8'($urandom) ^ 8'h5A;
        btn[0][0] = b1;
        btn[0][1] = 8'($urandom);
        bus_write(0, 2'd2, 8'h01);
        nd = 0; done_t = -1;
        for (int t = 1; t <= 150; t++) begin
            sel = 0;
            if (t == 20) begin cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 8'h01; end
            if (t == 30) begin cs = 1'b1; rd = 1'b1; addr = 2'd0; end
            if (t == 65 || t == 66) begin cs = 1'b1; rd = 1'b1; addr = 2'd2; end
            cyc();
            cs = 1'b0; rd = 1'b0; wr = 1'b0;
            if (done_v[0]) begin nd++; if (done_t < 0) done_t = t; end
            if (t == 30) begin
                checks++;
                if (rdata_v[0] !== prev) begin errors++; $display("FAIL midscan_read got %h want %h", rdata_v[0], prev); end
            end
            if (t == 65) begin
                checks++;
                if (rdata_v[0] !== 8'h01) begin errors++; $display("FAIL done_status_read got %h want 01", rdata_v[0]); end
            end
            if (t == 66) begin
                checks++;
                if (rdata_v[0] !== 8'h02) begin errors++; $display("FAIL post_done_status got %h want 02", rdata_v[0]); end
            end
        end
        checks++;
        if (nd != 1 || done_t != 65) begin
            errors++;
            $display("FAIL midscan_done_count got %0d at %0d want 1 at 65", nd, done_t);
        end
        exp_p[0][0] = b1;
        bus_read(0, 2'd0, prev);
        checks++;
        if (prev !== b1) begin errors++; $display("FAIL midscan_new_pad1 got %h want %h", prev, b1); end
    endtask

    task automatic test_reset_midscan();
        logic [7:0] d;
        int         nd;
        btn[0][0] = 8'($urandom);
        btn[0][1] = 8'($urandom);
        bus_write(0, 2'd2, 8'h01);
        repeat (25) cyc();
        checks++;
        if (c1[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_clk got %b want 1", c1[0]); end
        reset = 1'b1;
        cyc();
        checks++;
        if ({s1[0], s2[0], c1[0], c2[0]} !== 4'b0) begin
            errors++;
            $display("FAIL reset_midscan_pins got %b want 0000", {s1[0], s2[0], c1[0], c2[0]});
        end
        reset = 1'b0;
        nd = 0;
        for (int t = 0; t < 80; t++) begin
            cyc();
            if (done_v[0]) nd++;
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL reset_midscan_done got %0d want 0", nd); end
        for (int a = 0; a < 3; a++) begin
            bus_read(0, 2'(a), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL reset_midscan_addr%0d got %h want 00", a, d); end
        end
        exp_p[0][0] = 8'h00;
        exp_p[0][1] = 8'h00;
    endtask

`ifdef GAMEPAD_AUTOPOLL_EN
    task automatic test_autopoll();
        logic [7:0] d;
        int         t, nd, done_t;
        btn[2][0] = 8'($urandom);
        btn[2][1] = 8'($urandom);
        t = 0;
        while (!done_v[2] && t < 300) begin cyc(); t++; end
        checks++;
        if (!done_v[2]) begin errors++; $display("FAIL autopoll_first got timeout want scan_done"); return; end
        t = 0;
        do begin cyc(); t++; end while (!done_v[2] && t < 300);
        checks++;
        if (t != 100) begin errors++; $display("FAIL autopoll_period got %0d want 100", t); end
        repeat (34) cyc();
        bus_write(2, 2'd2, 8'h01);
        nd = 0; done_t = -1;
        for (int i = 1; i <= 99; i++) begin
            cyc();
            if (done_v[2]) begin nd++; if (done_t < 0) done_t = i; end
        end
        checks++;
        if (nd != 1 || done_t != 65) begin
            errors++;
            $display("FAIL autopoll_coincident got %0d dones at %0d want 1 at 65", nd, done_t);
        end
        bus_read(2, 2'd0, d);
        checks++;
        if (d !== btn[2][0]) begin errors++; $display("FAIL autopoll_pad1 got %h want %h", d, btn[2][0]); end
    endtask
`endif

    initial begin
        for (int k = 0; k < NI; k++) begin
            btn[k][0] = 8'h00; btn[k][1] = 8'h00;
            exp_p[k][0] = 8'h00; exp_p[k][1] = 8'h00;
        end
        test_reset();
        test_fixed_scan();
        test_random();
        test_midscan_write();
        test_reset_midscan();
`ifdef GAMEPAD_AUTOPOLL_EN
        test_autopoll();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
